// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues sequential PC reads to instruction memory and
// buffers {pc, instr} pairs in a small FIFO that feeds the decode handshake.
module if_fetch_unit #(
  parameter int unsigned          WORD_SIZE    = 32,
  parameter int unsigned          ADDR_SIZE    = 10,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0,
  parameter int unsigned          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 redirect,
  input  logic [ADDR_SIZE-1:0] redirect_target,
  output logic                 imem_req,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [ADDR_SIZE-1:0] out_pc
);

  localparam int unsigned          PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned          CntW     = PtrW + 2;
  localparam logic [CntW-1:0]      DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_SIZE-1:0] PcStep   = ADDR_SIZE'(4);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   pc_q;
  logic [ADDR_SIZE-1:0]   req_pc_q;
  logic                   inflight_q;
  logic [CntW-1:0]        count_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [PtrW-1:0]        wr_ptr_q;
  logic [WORD_SIZE-1:0]   instr_q  [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0]   pc_buf_q [FIFO_DEPTH];

  logic                   pop;
  logic                   push;
  logic [CntW-1:0]        occupancy;
  logic [ADDR_SIZE-1:0]   target_aligned;
  logic                   unused_tgt_lsbs;

  assign target_aligned  = {redirect_target[ADDR_SIZE-1:2], 2'b00};
  assign unused_tgt_lsbs = ^redirect_target[1:0];

  always_comb begin
    out_valid = (count_q != '0) && !rst;
    pop       = out_valid && out_ready && !redirect;
    // A response is dropped when a redirect lands in the cycle it returns.
    push      = inflight_q && !redirect && !rst;
    // Slots already promised: buffered + outstanding, minus the one leaving now.
    occupancy = count_q + CntW'(inflight_q) - CntW'(pop);
    imem_req  = en && !redirect && !rst && (state_q == StRun) && (occupancy < DepthCnt);
    imem_addr = pc_q;
    out_instr = instr_q[rd_ptr_q];
    out_pc    = pc_buf_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      req_pc_q   <= RESET_VECTOR;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= StRun;
      inflight_q <= imem_req;
      if (imem_req) begin
        req_pc_q <= pc_q;
      end
      if (redirect) begin
        pc_q     <= target_aligned;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (imem_req) begin
          pc_q <= pc_q + PcStep;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  // Payload storage carries no reset; it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q]  <= imem_rdata;
      pc_buf_q[wr_ptr_q] <= req_pc_q;
    end
  end

endmodule
